// File: rtl/iob_axistream_in_packer_if.sv
// Stream bus bundle: data, lane keep, valid/ready handshake and frame end.
// Latency: none, wires only.
// Backpressure: the slave drives tready, and the master holds the beat until tready.
interface iob_axistream_in_packer_if #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/iob_axistream_in_packer.sv
// Packs narrow stream beats into DATA_W words and queues them in a first-word-fall-through FIFO.
// Latency: a word is at the FIFO head one cycle after the beat that completes it.
// Backpressure: tready drops while the FIFO is full, and the consumer pops with sys.tready.
module iob_axistream_in_packer_fifo #(
    parameter int W      = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cke_i,
    input  logic              push_i,
    input  logic [W-1:0]      push_dat_i,
    input  logic              pop_i,
    output logic [W-1:0]      pop_dat_o,
    output logic [ADDR_W:0]   level_o,
    output logic              empty_o,
    output logic              full_o
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [W-1:0]      mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty_o   = (level_o == '0);
    assign full_o    = (level_o == (ADDR_W+1)'(DEPTH));
    assign do_push   = cke_i & push_i & ~full_o;
    assign do_pop    = cke_i & pop_i & ~empty_o;
    assign pop_dat_o = mem[rd_ptr];

    // Pointers wrap naturally; the level tracks the occupancy so that full and empty can be told apart.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_o <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_o <= level_o + 1'b1;
                2'b01:   level_o <= level_o - 1'b1;
                default: level_o <= level_o;
            endcase
        end
    end

    // The storage array has no reset, because its contents are only read while the level is non-zero.
    always_ff @(posedge clk_i) begin
        if (!rst_i && do_push) mem[wr_ptr] <= push_dat_i;
    end
endmodule

module iob_axistream_in_packer #(
    parameter int TDATA_W     = 8,
    parameter int DATA_W      = 32,
    parameter int FIFO_ADDR_W = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cke_i,
    input  logic                     enable_i,
    iob_axistream_in_packer_if.slave  axis,
    iob_axistream_in_packer_if.master sys,
    output logic [FIFO_ADDR_W:0]     fifo_level_o,
    output logic                     fifo_empty_o,
    output logic                     fifo_full_o,
    input  logic [FIFO_ADDR_W:0]     fifo_threshold_i,
    output logic                     interrupt_o,
    output logic [DATA_W-1:0]        nwords_o,
    output logic                     frame_done_o
);
    localparam int R      = DATA_W / TDATA_W;
    localparam int LANE_W = (R > 1) ? $clog2(R) : 1;
    localparam int WORD_W = 1 + R + DATA_W;

    logic [LANE_W-1:0] lane_idx;
    logic [DATA_W-1:0] part_dat;
    logic [R-1:0]      part_keep;
    logic [DATA_W-1:0] word_dat;
    logic [R-1:0]      word_keep;
    logic [DATA_W-1:0] beat_cnt;
    logic              beat_acc;
    logic              lane_last;
    logic              word_push;
    logic [WORD_W-1:0] head_word;

    assign axis.tready = cke_i & enable_i & ~fifo_full_o;
    assign beat_acc    = axis.tvalid & axis.tready;
    assign lane_last   = (lane_idx == LANE_W'(R - 1));
    assign word_push   = beat_acc & (lane_last | axis.tlast);

    // Merge the incoming beat into its lane of the partial word, so that a completing beat is pushed in the same cycle.
    always_comb begin
        word_dat  = part_dat;
        word_keep = part_keep;
        word_dat[lane_idx*TDATA_W +: TDATA_W] = axis.tdata;
        word_keep[lane_idx] = 1'b1;
    end

    // The partial word and lane index persist across idle and disabled cycles, and are cleared once a word leaves.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lane_idx  <= '0;
            part_dat  <= '0;
            part_keep <= '0;
        end else if (beat_acc) begin
            if (word_push) begin
                lane_idx  <= '0;
                part_dat  <= '0;
                part_keep <= '0;
            end else begin
                lane_idx  <= lane_idx + 1'b1;
                part_dat  <= word_dat;
                part_keep <= word_keep;
            end
        end
    end

    // Count the beats of the current frame, latch the total on tlast, and pulse frame_done for one enabled cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_cnt     <= '0;
            nwords_o     <= '0;
            frame_done_o <= 1'b0;
        end else if (cke_i) begin
            frame_done_o <= beat_acc & axis.tlast;
            if (beat_acc) begin
                if (axis.tlast) begin
                    nwords_o <= beat_cnt + 1'b1;
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    iob_axistream_in_packer_fifo #(
        .W      (WORD_W),
        .ADDR_W (FIFO_ADDR_W)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cke_i      (cke_i),
        .push_i     (word_push),
        .push_dat_i ({axis.tlast, word_keep, word_dat}),
        .pop_i      (sys.tready),
        .pop_dat_o  (head_word),
        .level_o    (fifo_level_o),
        .empty_o    (fifo_empty_o),
        .full_o     (fifo_full_o)
    );

    assign sys.tvalid  = ~fifo_empty_o;
    assign sys.tlast   = head_word[WORD_W-1];
    assign sys.tkeep   = head_word[DATA_W +: R];
    assign sys.tdata   = head_word[DATA_W-1:0];
    assign interrupt_o = (fifo_level_o >= fifo_threshold_i) & ~fifo_empty_o;
endmodule

// File: tb/tb_iob_axistream_in_packer.sv
// Testbench for the stream packer: a directed sequence followed by random traffic, checked against a queue-based model.
// Latency: outputs are sampled on the falling edge after each rising edge.
// Backpressure: acceptance is predicted from the model's FIFO occupancy.
module tb_iob_axistream_in_packer;
    logic       clk = 1'b0;
    logic       rst, cke, enable;
    logic [4:0] fifo_level, fifo_thr;
    logic       fifo_empty, fifo_full, intr, frame_done;
    logic [31:0] nwords;

    iob_axistream_in_packer_if #(.DATA_W(8),  .KEEP_W(1)) axis_if ();
    iob_axistream_in_packer_if #(.DATA_W(32), .KEEP_W(4)) sys_if ();

    iob_axistream_in_packer #(.TDATA_W(8), .DATA_W(32), .FIFO_ADDR_W(4)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cke_i            (cke),
        .enable_i         (enable),
        .axis             (axis_if),
        .sys              (sys_if),
        .fifo_level_o     (fifo_level),
        .fifo_empty_o     (fifo_empty),
        .fifo_full_o      (fifo_full),
        .fifo_threshold_i (fifo_thr),
        .interrupt_o      (intr),
        .nwords_o         (nwords),
        .frame_done_o     (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: stored words are packed as {last, keep[3:0], data[31:0]}.
    logic [36:0] q[$];
    logic [7:0]  part[$];
    int          fbeats;
    logic [31:0] m_nwords;
    bit          m_fd;
    bit          last_acc;
    int          n_asserts = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        part.delete();
        fbeats   = 0;
        m_nwords = 0;
        m_fd     = 0;
    endtask

    task automatic check_outputs();
        int n;
        n = q.size();
        chk("axis_tready", axis_if.tready, cke && enable && (n < 16));
        chk("sys_tvalid", sys_if.tvalid, n > 0);
        chk("fifo_level", fifo_level, n);
        chk("fifo_empty", fifo_empty, n == 0);
        chk("fifo_full", fifo_full, n == 16);
        chk("interrupt", intr, (n >= int'(fifo_thr)) && (n > 0));
        chk("nwords", nwords, m_nwords);
        chk("frame_done", frame_done, m_fd);
        if (n > 0) chk("head_word", {sys_if.tlast, sys_if.tkeep, sys_if.tdata}, q[0]);
    endtask

    // Advance one clock: predict acceptance and pop from the present inputs, then update the model and compare.
    task automatic cycle();
        bit          acc, pop, l;
        logic [7:0]  d;
        logic [31:0] wd;
        acc = !rst && cke && enable && axis_if.tvalid && (q.size() < 16);
        pop = !rst && cke && sys_if.tready && (q.size() > 0);
        d   = axis_if.tdata;
        l   = axis_if.tlast;
        @(posedge clk);
        @(negedge clk);
        last_acc = acc;
        if (rst) begin
            model_reset();
        end else begin
            if (cke) m_fd = acc && l;
            if (pop) void'(q.pop_front());
            if (acc) begin
                part.push_back(d);
                fbeats++;
                if (part.size() == 4 || l) begin
                    wd = 0;
                    for (int i = 0; i < part.size(); i++) wd = wd | (32'(part[i]) << (8 * i));
                    q.push_back({l, 4'((1 << part.size()) - 1), wd});
                    part.delete();
                end
                if (l) begin
                    m_nwords = fbeats;
                    fbeats   = 0;
                end
            end
        end
        check_outputs();
    endtask

    task automatic send_beat(input logic [7:0] d, input bit l);
        axis_if.tdata  = d;
        axis_if.tlast  = l;
        axis_if.tvalid = 1'b1;
        last_acc = 0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (last_acc) break;
        end
        chk("beat_accept_timeout", last_acc, 1'b1);
        axis_if.tvalid = 1'b0;
        axis_if.tlast  = 1'b0;
    endtask

    task automatic drain();
        sys_if.tready = 1'b1;
        for (int k = 0; k < 40 && q.size() > 0; k++) cycle();
        chk("drain_timeout", q.size(), 0);
        sys_if.tready = 1'b0;
        cycle();
    endtask

    initial begin
        rst = 1; cke = 1; enable = 1; fifo_thr = 5'd0;
        axis_if.tdata = 0; axis_if.tvalid = 0; axis_if.tlast = 0; axis_if.tkeep = 1'b1;
        sys_if.tready = 0;
        model_reset();
        cycle();
        cycle();
        chk("rst_empty", fifo_empty, 1'b1);
        chk("rst_tvalid", sys_if.tvalid, 1'b0);
        rst = 0;
        cycle();

        // One full word and a single frame.
        send_beat(8'h11, 0); send_beat(8'h22, 0); send_beat(8'h33, 0); send_beat(8'h44, 1);
        chk("w1_word", {sys_if.tlast, sys_if.tkeep, sys_if.tdata}, {1'b1, 4'hf, 32'h44332211});
        chk("w1_nwords", nwords, 32'd4);
        chk("w1_fd_pulse", frame_done, 1'b1);
        cycle();
        chk("w1_fd_single", frame_done, 1'b0);
        drain();

        // A six-beat frame splits into a full word and a two-lane tail.
        for (int i = 1; i <= 6; i++) send_beat(8'(i), i == 6);
        chk("w2_first", {sys_if.tlast, sys_if.tkeep, sys_if.tdata}, {1'b0, 4'hf, 32'h04030201});
        sys_if.tready = 1; cycle(); sys_if.tready = 0;
        chk("w2_second", {sys_if.tlast, sys_if.tkeep, sys_if.tdata}, {1'b1, 4'h3, 32'h00000605});
        chk("w2_nwords", nwords, 32'd6);
        drain();

        // Fill the FIFO, then check that the 65th beat stalls until one word is popped.
        for (int i = 0; i < 64; i++) send_beat(8'(i + 8'h40), 0);
        chk("full_level", fifo_level, 5'd16);
        chk("full_flag", fifo_full, 1'b1);
        axis_if.tdata = 8'hAB; axis_if.tvalid = 1;
        chk("full_stall", axis_if.tready, 1'b0);
        sys_if.tready = 1;
        cycle();
        sys_if.tready = 0;
        chk("after_pop_tready", axis_if.tready, 1'b1);
        cycle();
        chk("after_pop_accept", last_acc, 1'b1);
        axis_if.tvalid = 0;
        drain();
        send_beat(8'hCD, 0); send_beat(8'hEF, 0); send_beat(8'h12, 1);
        drain();

        // A push and a pop in the same cycle leave the level unchanged.
        for (int i = 0; i < 5; i++) send_beat(8'(8'hA0 + i), 1);
        chk("pp_level_before", fifo_level, 5'd5);
        axis_if.tdata = 8'h99; axis_if.tlast = 1; axis_if.tvalid = 1; sys_if.tready = 1;
        cycle();
        axis_if.tvalid = 0; axis_if.tlast = 0; sys_if.tready = 0;
        chk("pp_level_after", fifo_level, 5'd5);
        chk("pp_head", {sys_if.tlast, sys_if.tkeep, sys_if.tdata}, {1'b1, 4'h1, 32'h000000A1});
        drain();

        // A reset in the middle of a frame discards the partial word.
        send_beat(8'h55, 0); send_beat(8'h66, 0);
        rst = 1; cycle(); rst = 0;
        chk("rst_mid_level", fifo_level, 5'd0);
        cycle();
        for (int i = 1; i <= 4; i++) send_beat(8'(i), 0);
        chk("rst_mid_word", {sys_if.tlast, sys_if.tkeep, sys_if.tdata}, {1'b0, 4'hf, 32'h04030201});
        drain();

        // The interrupt follows the threshold.
        fifo_thr = 5'd3;
        send_beat(8'h01, 1); send_beat(8'h02, 1);
        chk("irq_level2", intr, 1'b0);
        send_beat(8'h03, 1);
        chk("irq_level3", intr, 1'b1);
        sys_if.tready = 1; cycle(); sys_if.tready = 0;
        chk("irq_drop", intr, 1'b0);
        drain();

        // With the clock enable low, all state holds.
        send_beat(8'h77, 0);
        cke = 0; axis_if.tvalid = 1; axis_if.tdata = 8'h88; sys_if.tready = 1;
        repeat (3) cycle();
        cke = 1; axis_if.tvalid = 0; sys_if.tready = 0;
        send_beat(8'h99, 1);
        chk("cke_word", {sys_if.tlast, sys_if.tkeep, sys_if.tdata}, {1'b1, 4'h3, 32'h00009977});
        drain();

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            axis_if.tvalid = ($urandom_range(0, 3) != 0);
            axis_if.tdata  = 8'($urandom);
            axis_if.tlast  = ($urandom_range(0, 7) == 0);
            enable         = ($urandom_range(0, 9) != 0);
            cke            = ($urandom_range(0, 9) != 0);
            sys_if.tready  = ($urandom_range(0, 2) == 0);
            rst            = ($urandom_range(0, 99) == 0);
            if (c % 50 == 0) fifo_thr = 5'($urandom_range(0, 16));
            cycle();
        end
        rst = 0; cke = 1; enable = 1; axis_if.tvalid = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
